// File: rtl/fp_div_seq_if.sv
// rtl/fp_div_seq_if.sv - request/result bundle for the sequential FP divider
//
// Signals:
//   start          request a division (honoured only when the divider is idle)
//   a, b           IEEE754 single-precision dividend / divisor
//   out            registered quotient, held until the next result
//   busy           high while the iterative divide or normalise step runs
//   done           one-cycle pulse marking out valid
//   check_special  registered: operation was resolved as a special case
interface fp_div_seq_if;
  logic        start;
  logic [31:0] a;
  logic [31:0] b;
  logic [31:0] out;
  logic        busy;
  logic        done;
  logic        check_special;

  modport master (
    output start, a, b,
    input  out, busy, done, check_special
  );

  modport slave (
    input  start, a, b,
    output out, busy, done, check_special
  );
endinterface

// File: rtl/fp_div_seq.sv
// rtl/fp_div_seq.sv - sequential IEEE754 single-precision divider (restoring, RNE)
//
// Ports:
//   clk   single clock, rising edge
//   rst   asynchronous active-high reset
//   bus   fp_div_seq_if.slave: start/a/b in, out/busy/done/check_special out
//
// Special operands resolve in one cycle (IDLE -> DONE). Normal/normal
// operands run 26 restoring-division steps (DIV), one normalise/round
// cycle (NORM), then a one-cycle DONE. Subnormals are flushed to zero.
module fp_div_seq (
  input  logic         clk,
  input  logic         rst,
  fp_div_seq_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, DIV, NORM, DONE} state_t;

  state_t state, state_nx;

  logic [25:0]        q;
  logic [24:0]        rem;
  logic [23:0]        dvsr;
  logic signed [9:0]  exp_r;
  logic               sign_r;
  logic [4:0]         cnt;
  logic [31:0]        out_r;
  logic               chk_r;

  // Operand classification
  logic a_zero, a_inf, a_nan, b_zero, b_inf, b_nan;
  logic special_hit;
  logic [31:0] special_res;

  always_comb begin
    a_zero = (bus.a[30:23] == 8'h00);
    b_zero = (bus.b[30:23] == 8'h00);
    a_inf  = (bus.a[30:23] == 8'hFF) && (bus.a[22:0] == 23'h0);
    b_inf  = (bus.b[30:23] == 8'hFF) && (bus.b[22:0] == 23'h0);
    a_nan  = (bus.a[30:23] == 8'hFF) && (bus.a[22:0] != 23'h0);
    b_nan  = (bus.b[30:23] == 8'hFF) && (bus.b[22:0] != 23'h0);
    // Anything other than normal/normal is handled without iterating.
    special_hit = a_zero | a_inf | a_nan | b_zero | b_inf | b_nan;

    // Once the NaN-producing combinations are excluded, a zero dividend or
    // an infinite divisor gives zero; everything left (Inf/x, x/0) is Inf.
    if (a_nan || b_nan || (a_zero && b_zero) || (a_inf && b_inf)) begin
      special_res = 32'hFF800001;
    end else if (a_zero || b_inf) begin
      special_res = 32'h00000000;
    end else begin
      special_res = {bus.a[31] ^ bus.b[31], 8'hFF, 23'h0};
    end
  end

  // One restoring step: the partial remainder never exceeds twice the
  // divisor, so 25 bits are enough and the shifted result fits again.
  logic        rem_ge;
  logic [24:0] rem_sub;
  logic [24:0] rem_next;

  always_comb begin
    rem_ge   = (rem >= {1'b0, dvsr});
    rem_sub  = rem_ge ? (rem - {1'b0, dvsr}) : rem;
    rem_next = {rem_sub[23:0], 1'b0};
  end

  // Normalise and round-to-nearest-even from the finished quotient.
  logic [22:0]       mant;
  logic              guard;
  logic              sticky;
  logic              round_up;
  logic [23:0]       mant_r;
  logic signed [9:0] exp_n;
  logic signed [9:0] exp_f;
  logic [31:0]       norm_res;

  always_comb begin
    if (q[25]) begin
      mant   = q[24:2];
      guard  = q[1];
      sticky = q[0] | (rem != 25'h0);
      exp_n  = exp_r;
    end else begin
      mant   = q[23:1];
      guard  = q[0];
      sticky = (rem != 25'h0);
      exp_n  = exp_r - 10'sd1;
    end
    round_up = guard & (sticky | mant[0]);
    mant_r   = {1'b0, mant} + {23'h0, round_up};
    // Rounding carry-out leaves mant_r[22:0] at zero: 1.111.. -> 10.000..
    exp_f    = exp_n + $signed({9'h0, mant_r[23]});
    if (exp_f >= 10'sd255) begin
      norm_res = {sign_r, 8'hFF, 23'h0};
    end else if (exp_f <= 10'sd0) begin
      norm_res = 32'h00000000;
    end else begin
      norm_res = {sign_r, exp_f[7:0], mant_r[22:0]};
    end
  end

  // Next-state logic
  always_comb begin
    state_nx = state;
    case (state)
      IDLE: begin
        if (bus.start) begin
          state_nx = special_hit ? DONE : DIV;
        end
      end
      DIV: begin
        if (cnt == 5'd25) begin
          state_nx = NORM;
        end
      end
      NORM:    state_nx = DONE;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      q      <= 26'h0;
      rem    <= 25'h0;
      dvsr   <= 24'h0;
      exp_r  <= 10'sd0;
      sign_r <= 1'b0;
      cnt    <= 5'd0;
      out_r  <= 32'h0;
      chk_r  <= 1'b0;
    end else begin
      state <= state_nx;
      case (state)
        IDLE: begin
          if (bus.start) begin
            chk_r <= special_hit;
            if (special_hit) begin
              out_r <= special_res;
            end else begin
              sign_r <= bus.a[31] ^ bus.b[31];
              exp_r  <= $signed({2'b00, bus.a[30:23]})
                      - $signed({2'b00, bus.b[30:23]}) + 10'sd127;
              rem    <= {2'b01, bus.a[22:0]};
              dvsr   <= {1'b1, bus.b[22:0]};
              q      <= 26'h0;
              cnt    <= 5'd0;
            end
          end
        end
        DIV: begin
          q   <= {q[24:0], rem_ge};
          rem <= rem_next;
          cnt <= cnt + 5'd1;
        end
        NORM: begin
          out_r <= norm_res;
        end
        default: ;
      endcase
    end
  end

  assign bus.out           = out_r;
  assign bus.check_special = chk_r;
  assign bus.busy          = (state == DIV) || (state == NORM);
  assign bus.done          = (state == DONE);

endmodule

// File: tb/tb_fp_div_seq.sv
// tb/tb_fp_div_seq.sv - self-checking bench for fp_div_seq
module tb_fp_div_seq;

  logic clk;
  logic rst;
  int   n_assert;
  int   n_fail;

  fp_div_seq_if bus ();

  fp_div_seq dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_assert++;
    assert (obs === expv)
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  // Reference: exact integer quotient/remainder of the significands,
  // rounded by comparing twice the remainder with the divisor.
  task automatic model(input logic [31:0] a, input logic [31:0] b,
                       output logic [31:0] res, output logic spec);
    logic [7:0]  ea, eb;
    logic [22:0] ma, mb;
    bit za, zb, ia, ib, na, nb, sgn;
    longint dd, dv, m, r;
    int e;
    ea = a[30:23]; eb = b[30:23]; ma = a[22:0]; mb = b[22:0];
    za = (ea == 0); zb = (eb == 0);
    ia = (ea == 255) && (ma == 0); ib = (eb == 255) && (mb == 0);
    na = (ea == 255) && (ma != 0); nb = (eb == 255) && (mb != 0);
    sgn = a[31] ^ b[31];
    spec = za | zb | ia | ib | na | nb;
    if (na || nb)      res = 32'hFF800001;
    else if (za && zb) res = 32'hFF800001;
    else if (ia && ib) res = 32'hFF800001;
    else if (za)       res = 32'h0;
    else if (ib)       res = 32'h0;
    else if (ia || zb) res = {sgn, 8'hFF, 23'h0};
    else begin
      dd = longint'({1'b1, ma});
      dv = longint'({1'b1, mb});
      e  = int'(ea) - int'(eb) + 127;
      if (dd >= dv) begin
        m = (dd << 23) / dv; r = (dd << 23) % dv;
      end else begin
        m = (dd << 24) / dv; r = (dd << 24) % dv; e = e - 1;
      end
      if ((2 * r > dv) || ((2 * r == dv) && (m % 2 == 1))) m = m + 1;
      if (m == 64'd16777216) begin
        m = 64'd8388608; e = e + 1;
      end
      if (e >= 255)    res = {sgn, 8'hFF, 23'h0};
      else if (e <= 0) res = 32'h0;
      else             res = {sgn, 8'(e), 23'(m)};
    end
  endtask

  function automatic logic [31:0] rand_fp();
    int sel;
    logic [7:0] e;
    logic [22:0] m;
    bit s;
    sel = int'($urandom_range(0, 9));
    m = 23'($urandom);
    s = bit'($urandom_range(0, 1));
    case (sel)
      0: e = 8'h00;
      1: begin e = 8'hFF; m = 23'h0; end
      2: begin e = 8'hFF; m = m | 23'h1; end
      3: e = ($urandom_range(0, 1) == 1) ? 8'($urandom_range(1, 3)) : 8'($urandom_range(252, 254));
      default: e = 8'($urandom_range(1, 254));
    endcase
    return {s, e, m};
  endfunction

  // Runs one operation and checks result, flag, latency, busy span and
  // the single-cycle done pulse. poke pulses start mid-operation.
  task automatic do_op(input logic [31:0] a, input logic [31:0] b, input bit poke,
                       input bit use_dir, input logic [31:0] dir);
    logic [31:0] want;
    logic spec;
    int lat, busy_cnt;
    bit got;
    string tg;
    model(a, b, want, spec);
    tg = $sformatf("%h/%h", a, b);
    @(negedge clk);
    bus.a = a; bus.b = b; bus.start = 1'b1;
    @(posedge clk);
    #1 bus.start = 1'b0;
    lat = 0; busy_cnt = 0; got = 0;
    while (!got && lat < 40) begin
      @(negedge clk);
      lat++;
      if (bus.busy) busy_cnt++;
      if (bus.done) got = 1;
      else if (poke && lat == 5) begin
        bus.start = 1'b1; bus.a = $urandom; bus.b = $urandom;
      end else bus.start = 1'b0;
    end
    bus.start = 1'b0;
    check({"done_seen ", tg}, 32'(got), 32'd1);
    check({"latency ", tg}, 32'(lat), spec ? 32'd1 : 32'd28);
    check({"busy_cycles ", tg}, 32'(busy_cnt), spec ? 32'd0 : 32'd27);
    check({"out ", tg}, bus.out, want);
    check({"check_special ", tg}, 32'(bus.check_special), 32'(spec));
    if (use_dir) check({"directed ", tg}, bus.out, dir);
    @(negedge clk);
    check({"done_pulse ", tg}, 32'(bus.done), 32'd0);
  endtask

  initial begin
    int dcnt;
    n_assert = 0; n_fail = 0;
    rst = 1'b1;
    bus.start = 1'b0; bus.a = 32'h0; bus.b = 32'h0;
    #12;
    check("reset_out", bus.out, 32'h0);
    check("reset_busy", 32'(bus.busy), 32'd0);
    check("reset_done", 32'(bus.done), 32'd0);
    check("reset_chk", 32'(bus.check_special), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    do_op(32'h40C00000, 32'h40000000, 0, 1, 32'h40400000);
    do_op(32'h3F800000, 32'h40400000, 0, 1, 32'h3EAAAAAB);
    do_op(32'h00000000, 32'h00000000, 0, 1, 32'hFF800001);
    do_op(32'hBF800000, 32'h00000000, 0, 1, 32'hFF800000);
    do_op(32'h40000000, 32'h7F800000, 0, 1, 32'h00000000);
    do_op(32'h7F000000, 32'h00800000, 0, 1, 32'h7F800000);
    do_op(32'h00800000, 32'h7F000000, 0, 1, 32'h00000000);
    do_op(32'h3F800000, 32'h40400000, 0, 1, 32'h3EAAAAAB);

    // Abort a 6.0/2.0 division with reset ten edges after acceptance.
    @(negedge clk);
    bus.a = 32'h40C00000; bus.b = 32'h40000000; bus.start = 1'b1;
    @(posedge clk);
    #1 bus.start = 1'b0;
    repeat (10) @(posedge clk);
    #1 rst = 1'b1;
    #1;
    check("abort_out", bus.out, 32'h0);
    check("abort_busy", 32'(bus.busy), 32'd0);
    check("abort_done", 32'(bus.done), 32'd0);
    check("abort_chk", 32'(bus.check_special), 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    dcnt = 0;
    repeat (35) begin
      @(negedge clk);
      if (bus.done) dcnt++;
    end
    check("abort_no_done", 32'(dcnt), 32'd0);
    do_op(32'h3F800000, 32'h40000000, 1, 1, 32'h3F000000);

    for (int i = 0; i < 60; i++) begin
      do_op(rand_fp(), rand_fp(), (i % 7) == 3, 0, 32'h0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/fp_div_seq.md
FP_DIV_SEQ -- requirements
Module: fp_div_seq

Interface
REQ-001 The block SHALL have port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-002 The block SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-003 The block SHALL have port start, input, 1 bit: request a division; honoured only in IDLE.
REQ-004 The block SHALL have ports a and b, input, 32 bits each: IEEE754 single-precision dividend and divisor; sampled on the accepting edge.
REQ-005 The block SHALL have port out, output, 32 bits: quotient; registered and held until the next result.
REQ-006 The block SHALL have port busy, output, 1 bit: high while the state is DIV or NORM.
REQ-007 The block SHALL have port done, output, 1 bit: one-cycle pulse marking out valid.
REQ-008 The block SHALL have port check_special, output, 1 bit: registered; set on accept, high for the whole operation, held until the next accept.

Function
REQ-009 Operand classification SHALL be:
- exp==0: Zero (subnormals flushed).
- exp==255, mantissa==0: Inf, signed.
- exp==255, mantissa!=0: NaN.
- otherwise: Normal.
REQ-010 Special-case result constants SHALL be: NaN 32'hFF800001; Zero 32'h00000000 (always positive); Inf {a[31]^b[31], 8'hFF, 23'h0}.
REQ-011 Special cases, in priority order, SHALL be:
- either operand NaN -> NaN.
- 0/0 -> NaN.
- Inf/Inf -> NaN.
- 0/(Normal or Inf) -> Zero.
- Normal/Inf -> Zero.
- Inf/(Normal or 0) -> Inf.
- Normal/0 -> Inf.
check_special SHALL be 1 for any of these and 0 for Normal/Normal.
REQ-012 The FSM SHALL have states IDLE, DIV, NORM and DONE.
- IDLE with start=1 and a special case: go to DONE; out is loaded on the same edge.
- IDLE with start=1 and Normal/Normal: go to DIV.
- DIV: stay 26 cycles, then go to NORM.
- NORM: go to DONE.
- DONE: go to IDLE unconditionally.
REQ-013 done SHALL be 1 exactly while in DONE.
REQ-014 start SHALL be ignored in DIV, NORM and DONE; no queuing.
REQ-015 Normal path setup:
- sign = a[31]^b[31].
- exponent = ea - eb + 127, held as a 10-bit signed value.
- dividend = {1,ma} and divisor = {1,mb}, 24 bits each.
REQ-016 DIV SHALL perform restoring division, one quotient bit per cycle: 26 bits q = floor(dividend*2^25/divisor), with remainder kept.
REQ-017 NORM, q[25]=1 case: mantissa q[24:2], guard q[1], sticky q[0]|(rem!=0).
REQ-018 NORM, q[25]=0 case: exponent decremented by 1; mantissa q[23:1], guard q[0], sticky (rem!=0).
REQ-019 Rounding SHALL be round-to-nearest-even: increment if guard & (sticky | lsb); a mantissa carry-out increments the exponent.
REQ-020 After rounding:
- exponent >= 255 -> signed Inf.
- exponent <= 0 -> Zero (32'h0).
- otherwise -> {sign, exp[7:0], mantissa[22:0]}.
REQ-021 Latency, start accepted at edge k: special case, done high in the cycle after edge k; Normal, done high in the cycle after edge k+27.
REQ-022 A new start SHALL be accepted at earliest on the edge ending DONE+1 (IDLE).

Reset
REQ-023 While rst=1, regardless of clk: state IDLE, out=32'h0, done=0, busy=0, check_special=0.
REQ-024 Internal quotient, remainder and exponent registers SHALL be cleared by rst.
REQ-025 Reset mid-operation SHALL abort the operation; no done pulse for it; the next start after release is accepted normally.

Verification
REQ-026 Scenario: a=32'h40C00000 (6.0), b=32'h40000000 (2.0), start -> out=32'h40400000, check_special=0, done one cycle after edge k+27, busy high for 27 cycles.
REQ-027 Scenario: a=32'h3F800000, b=32'h40400000 (1/3) -> out=32'h3EAAAAAB (round-up path).
REQ-028 Scenario: a=0, b=0 -> out=32'hFF800001, check_special=1, done in the cycle after the accept edge.
REQ-029 Scenario: a=32'hBF800000 (-1.0), b=0 -> out=32'hFF800000.
REQ-029b Scenario: a=32'h40000000, b=32'h7F800000 -> out=32'h0.
REQ-030 Scenario: a=32'h7F000000, b=32'h00800000 -> out=32'h7F800000 (overflow).
REQ-030b Scenario: a=32'h00800000, b=32'h7F000000 -> out=32'h0 (underflow).
REQ-031 Scenario: start 6.0/2.0, assert rst at edge k+10 -> out=0, busy=0, no done.
REQ-031b Scenario: after reset release, start 1.0/2.0 -> out=32'h3F000000 with correct latency; a start pulsed during DIV is ignored.
